pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline (IF, ID, EX, MM, WB). It merges four hold sources into per-stage hold and bubble controls:
- the dependency stall from the forwarding unit,
- the multi-cycle divider occupying EX,
- instruction-bus wait,
- data-bus wait.

It also applies exception flushes from MM. It owns the divider occupancy FSM and the discard tracking for instruction fetches that were in flight when a flush occurred.

---
 rtl/pipeline_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: merges hold sources into
// per-stage stall/bubble controls, runs the divider occupancy FSM and drops stale fetches.
module pipeline_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic fwd_stall,
  input  logic div_start,
  input  logic ibus_req,
  input  logic ibus_ready,
  input  logic dbus_req,
  input  logic dbus_ready,
  input  logic exc_valid,
  output logic stall_if,
  output logic stall_id,
  output logic stall_ex,
  output logic stall_mm,
  output logic flush_id,
  output logic flush_ex,
  output logic flush_mm,
  output logic flush_wb,
  output logic div_busy,
  output logic div_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 1);

  div_state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       drop_pend, drop_nxt;

  logic ibus_wait, dbus_wait, exc_flush, div_hold;
  logic s_if, s_id, s_ex, s_mm;
  logic f_id, f_ex, f_mm, f_wb;

  assign ibus_wait = ibus_req & ~ibus_ready;
  assign dbus_wait = dbus_req & ~dbus_ready;
  // A pending data access pins the excepting instruction in MM until it completes.
  assign exc_flush = exc_valid & ~dbus_wait;
  assign div_hold  = ((state == IDLE) & div_start) | (state == RUN);

  always_comb begin
    s_mm = dbus_wait;
    s_ex = s_mm | div_hold;
    s_id = s_ex | fwd_stall;
    s_if = s_id | ibus_wait;
    f_wb = s_mm;
    f_mm = s_ex & ~s_mm;
    f_ex = s_id & ~s_ex;
    f_id = s_if & ~s_id;
    if (exc_flush) begin
      s_if = 1'b0;
      s_id = 1'b0;
      s_ex = 1'b0;
      s_mm = 1'b0;
      f_id = 1'b1;
      f_ex = 1'b1;
      f_mm = 1'b1;
      f_wb = 1'b0;
    end
    // Data returning for a fetch issued before the flush is discarded as a bubble.
    if (drop_pend & ibus_ready) begin
      f_id = 1'b1;
      s_if = 1'b0;
    end
    if (!resetn) begin
      s_if = 1'b0;
      s_id = 1'b0;
      s_ex = 1'b0;
      s_mm = 1'b0;
      f_id = 1'b0;
      f_ex = 1'b0;
      f_mm = 1'b0;
      f_wb = 1'b0;
    end
  end

  assign stall_if = s_if;
  assign stall_id = s_id;
  assign stall_ex = s_ex;
  assign stall_mm = s_mm;
  assign flush_id = f_id;
  assign flush_ex = f_ex;
  assign flush_mm = f_mm;
  assign flush_wb = f_wb;
  assign div_busy = resetn & (state == RUN);
  assign div_done = resetn & (state == DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (div_start & ~exc_flush) begin
        state_nxt = RUN;
        cnt_nxt   = CNT_INIT;
      end
      RUN: begin
        if (exc_flush)      state_nxt = IDLE;
        else if (cnt == 0)  state_nxt = DONE;
        else                cnt_nxt   = cnt - 6'd1;
      end
      DONE: if (exc_flush | ~s_mm) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign drop_nxt = (drop_pend & ~ibus_ready) | (exc_flush & ibus_wait);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      drop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      drop_pend <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized scoreboard bench for pipeline_ctrl against a stage-depth reference model.
module tb_pipeline_ctrl;

  localparam int DIVC   = 4;
  localparam int NCYC   = 4000;

  logic clk = 1'b0;
  logic resetn;
  logic fwd_stall, div_start, ibus_req, ibus_ready, dbus_req, dbus_ready, exc_valid;
  logic stall_if, stall_id, stall_ex, stall_mm;
  logic flush_id, flush_ex, flush_mm, flush_wb, div_busy, div_done;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk(clk), .resetn(resetn),
    .fwd_stall(fwd_stall), .div_start(div_start),
    .ibus_req(ibus_req), .ibus_ready(ibus_ready),
    .dbus_req(dbus_req), .dbus_ready(dbus_ready),
    .exc_valid(exc_valid),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mm(stall_mm),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mm(flush_mm), .flush_wb(flush_wb),
    .div_busy(div_busy), .div_done(div_done)
  );

  // Output vector layout: stall if,id,ex,mm | flush id,ex,mm,wb | busy | done
  logic [9:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: RUN cycles still to go, whether a result is parked, fetch drop.
  int run_left;
  bit parked;
  bit drop;

  function automatic logic [9:0] model_step(input bit rst_low, input bit advance);
    logic [9:0] o;
    bit iw, dw, exf, idle, dh, drop_now;
    int deepest;
    bit [3:0] st, fl;
    o = '0;
    if (rst_low) begin
      if (advance) begin run_left = 0; parked = 0; drop = 0; end
      return o;
    end
    iw   = ibus_req & !ibus_ready;
    dw   = dbus_req & !dbus_ready;
    exf  = exc_valid & !dw;
    idle = (run_left == 0) && !parked;
    dh   = (idle && div_start) || (run_left > 0);
    // deepest held stage: 0=IF 1=ID 2=EX 3=MM, -1 none
    deepest = dw ? 3 : dh ? 2 : fwd_stall ? 1 : iw ? 0 : -1;
    st = '0; fl = '0;
    for (int k = 0; k < 4; k++) st[k] = (k <= deepest);
    if (deepest >= 0) fl[deepest] = 1'b1;   // fl[k] = bubble into stage k+1
    if (exf) begin st = '0; fl = 4'b0111; end
    drop_now = drop && ibus_ready;
    if (drop_now) begin fl[0] = 1'b1; st[0] = 1'b0; end
    o = {st[0], st[1], st[2], st[3], fl[0], fl[1], fl[2], fl[3],
         1'(run_left > 0), 1'(parked)};
    if (advance) begin
      if (exf && !idle) begin
        run_left = 0; parked = 0;
      end else if (idle) begin
        if (div_start && !exf) run_left = DIVC;
      end else if (run_left > 0) begin
        run_left--;
        if (run_left == 0) parked = 1;
      end else if (parked && !dw) begin
        parked = 0;
      end
      drop = (drop && !ibus_ready) || (exf && iw);
    end
    return o;
  endfunction

  task automatic push_cycle();
    exp_q.push_back(model_step(!resetn, 1'b1));
  endtask

  // Monitor: pops one expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    logic [9:0] act, exp_v;
    act = {stall_if, stall_id, stall_ex, stall_mm, flush_id, flush_ex, flush_mm, flush_wb,
           div_busy, div_done};
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL outputs t=%0t got=%b expected=%b", $time, act, exp_v);
      end
    end
  end

  task automatic idle_inputs();
    fwd_stall = 0; div_start = 0; ibus_req = 0; ibus_ready = 0;
    dbus_req = 0; dbus_ready = 0; exc_valid = 0;
  endtask

  initial begin
    run_left = 0; parked = 0; drop = 0;
    resetn = 1'b0;
    idle_inputs();
    div_start = 1'b1; fwd_stall = 1'b1;  // outputs must stay 0 in reset regardless
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      push_cycle();
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    idle_inputs();
    // Directed: lone dependency stall, then a clean divide.
    fwd_stall = 1'b1;
    push_cycle();
    @(posedge clk); #1;
    fwd_stall = 1'b0; div_start = 1'b1;
    for (int i = 0; i < DIVC + 3; i++) begin
      push_cycle();
      @(posedge clk); #1;
    end
    idle_inputs();
    for (int c = 0; c < NCYC; c++) begin
      if (c == NCYC / 2) begin
        resetn = 1'b0;
        push_cycle();
        @(posedge clk); #1;
        resetn = 1'b1;
      end
      fwd_stall  = ($urandom_range(0, 5) == 0);
      div_start  = ($urandom_range(0, 2) == 0);
      ibus_req   = ($urandom_range(0, 1) == 0);
      ibus_ready = ($urandom_range(0, 2) == 0);
      dbus_req   = ($urandom_range(0, 2) == 0);
      dbus_ready = ($urandom_range(0, 1) == 0);
      exc_valid  = ($urandom_range(0, 9) == 0);
      push_cycle();
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
